usrt_tx_shifter: RTL

- Serializer stage directly downstream of the transmit parity/framing block.
- Accepts one pre-built 11-bit frame per valid/ready handshake and shifts it out LSB-first on o_Tx.
- Generates a gated serial bit clock o_Sclk; the link partner samples o_Tx on the o_Sclk rising edge.
- Frame length depends on the parity mode; an optional second stop bit is supported.

---
 rtl/usrt_tx_shifter_if.sv | 22 ++
 rtl/usrt_tx_shifter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/usrt_tx_shifter_if.sv
// Handshake and serial-line bundle between the framing block, the serializer
// and the link pins.
interface usrt_tx_shifter_if;
    logic [10:0] i_Frame;
    logic [1:0]  i_Parity;
    logic        i_Valid;
    logic        o_Ready;
    logic        o_Tx;
    logic        o_Sclk;
    logic        o_Busy;
    logic        o_Done;

    modport master (
        output i_Frame, i_Parity, i_Valid,
        input  o_Ready, o_Tx, o_Sclk, o_Busy, o_Done
    );

    modport slave (
        input  i_Frame, i_Parity, i_Valid,
        output o_Ready, o_Tx, o_Sclk, o_Busy, o_Done
    );
endinterface

// File: rtl/usrt_tx_shifter.sv
// Synchronous serializer: shifts one framed word out LSB-first with a gated
// bit clock whose rising edge sits mid-bit; optional generated second stop bit.
module usrt_tx_shifter #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic            i_Pclk,
    input  logic            i_Reset,
    usrt_tx_shifter_if.slave bus
);
    localparam int PHASE_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP2 = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [10:0]        shift_reg,   shift_next;
    logic [3:0]         bit_cnt_reg, bit_cnt_next;
    logic [3:0]         nbits_reg,   nbits_next;
    logic [PHASE_W-1:0] phase_reg,   phase_next;

    logic tx_reg,    tx_next;
    logic sclk_reg,  sclk_next;
    logic ready_reg, ready_next;
    logic busy_reg,  busy_next;
    logic done_reg,  done_next;

    logic        accept;
    logic        has_parity;
    logic        phase_end;
    logic        last_bit;
    logic [10:0] load_word;

    assign accept     = ready_reg && bus.i_Valid;
    assign has_parity = (bus.i_Parity == 2'b01) || (bus.i_Parity == 2'b10);
    assign phase_end  = (phase_reg == PHASE_LAST);
    assign last_bit   = (bit_cnt_reg == (nbits_reg - 4'd1));

    // Without parity the stop bit is moved down into slot 9 so the shifter
    // never has to skip a position; the top slot is padding that never leaves.
    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_load
            if (gi < 9) begin : g_data
                assign load_word[gi] = bus.i_Frame[gi];
            end else if (gi == 9) begin : g_par_or_stop
                assign load_word[gi] = has_parity ? bus.i_Frame[9] : bus.i_Frame[10];
            end else begin : g_top
                assign load_word[gi] = has_parity ? bus.i_Frame[10] : 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            nbits_reg   <= '0;
            phase_reg   <= '0;
            tx_reg      <= 1'b1;
            sclk_reg    <= 1'b0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            nbits_reg   <= nbits_next;
            phase_reg   <= phase_next;
            tx_reg      <= tx_next;
            sclk_reg    <= sclk_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        nbits_next   = nbits_reg;
        phase_next   = phase_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_SHIFT;
                    shift_next   = load_word;
                    bit_cnt_next = 4'd0;
                    nbits_next   = has_parity ? 4'd11 : 4'd10;
                    phase_next   = '0;
                end
            end
            ST_SHIFT: begin
                if (phase_end) begin
                    phase_next = '0;
                    if (last_bit) begin
                        bit_cnt_next = 4'd0;
                        state_next   = (STOP_BITS == 2) ? ST_STOP2 : ST_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        shift_next   = {1'b1, shift_reg[10:1]};
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            ST_STOP2: begin
                if (phase_end) begin
                    phase_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so the line, the bit
    // clock and the handshake all change on the same edge as the state.
    always_comb begin
        tx_next    = 1'b1;
        sclk_next  = 1'b0;
        ready_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;

        if (state_next == ST_SHIFT) begin
            tx_next = shift_next[0];
        end
        if (state_next != ST_IDLE) begin
            sclk_next = (phase_next >= PHASE_HALF);
            busy_next = 1'b1;
        end else begin
            ready_next = 1'b1;
        end
        done_next = (state_reg != ST_IDLE) && (state_next == ST_IDLE);
    end

    assign bus.o_Tx    = tx_reg;
    assign bus.o_Sclk  = sclk_reg;
    assign bus.o_Ready = ready_reg;
    assign bus.o_Busy  = busy_reg;
    assign bus.o_Done  = done_reg;

endmodule
